micro_lsu: RTL

MICRO_LSU -- requirements
Module: micro_lsu

---
 rtl/micro_lsu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/micro_lsu.sv
// Single-outstanding load/store unit: accepts one decoded micro command, issues at most
// one word-aligned bus request, extends load data and reports done/err/writeback for one cycle.
module micro_lsu #(
  parameter int unsigned MICRO_LEN = 14,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [MICRO_LEN-1:0] micro_cmd,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [4:0]           rd,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  output logic                 mem_req_wen,
  output logic [3:0]           mem_req_wmask,
  output logic [31:0]          mem_req_wdata,
  input  logic                 mem_resp_valid,
  input  logic [31:0]          mem_resp_rdata,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned XLEN  = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_d, wb_d, accept_c;
  logic [1:0]        mwen_c, mren_c, size_c;
  logic              misalign_c;
  logic [3:0]        wmask_c;
  logic [XLEN-1:0]   wdata_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [XLEN-1:0]   ld_val_c;

  logic              lat_regen, lat_unsign, lat_load;
  logic [1:0]        lat_size, lat_lane;
  logic [4:0]        lat_rd;

  // Decoder fields that only matter to other pipeline stages.
  logic unused_fields;
  assign unused_fields = ^{micro_cmd[12:11], micro_cmd[6:4], micro_cmd[2:0]};

  // Next state, request formatting and load extension.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    wb_d       = 1'b0;
    accept_c   = 1'b0;
    mwen_c     = micro_cmd[10:9];
    mren_c     = micro_cmd[8:7];
    size_c     = mwen_c | mren_c;
    misalign_c = ((size_c == 2'b10) && addr[0]) ||
                 ((size_c == 2'b11) && (addr[1:0] != 2'b00));

    wmask_c = 4'b0000;
    case (mwen_c)
      2'b01:   wmask_c = 4'b0001 << addr[1:0];
      2'b10:   wmask_c = 4'b0011 << addr[1:0];
      2'b11:   wmask_c = 4'b1111;
      default: wmask_c = 4'b0000;
    endcase

    case (mwen_c)
      2'b01:   wdata_c = {4{wdata[7:0]}};
      2'b10:   wdata_c = {2{wdata[15:0]}};
      default: wdata_c = wdata;
    endcase

    byte_c = mem_resp_rdata[{lat_lane, 3'b000} +: 8];
    half_c = mem_resp_rdata[{lat_lane[1], 4'b0000} +: 16];
    case (lat_size)
      2'b01:   ld_val_c = lat_unsign ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b10:   ld_val_c = lat_unsign ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: ld_val_c = mem_resp_rdata;
    endcase

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept_c = 1'b1;
          if ((mwen_c == 2'b00) && (mren_c == 2'b00)) begin
            state_d = DONE;
          end else if (((mwen_c != 2'b00) && (mren_c != 2'b00)) || misalign_c) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = DONE;
          wb_d    = lat_load & lat_regen;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Response in the last allowed cycle still wins over the timeout.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wmask <= '0;
      mem_req_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      lat_regen     <= 1'b0;
      lat_unsign    <= 1'b0;
      lat_load      <= 1'b0;
      lat_size      <= '0;
      lat_lane      <= '0;
      lat_rd        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready     <= (state_d == IDLE);
      mem_req_valid <= (state_d == REQ);
      done          <= (state_d == DONE);
      err           <= err_d;
      wb_valid      <= wb_d;
      if (wb_d) begin
        wb_rd   <= lat_rd;
        wb_data <= ld_val_c;
      end
      if (accept_c) begin
        lat_regen  <= micro_cmd[13];
        lat_unsign <= micro_cmd[3];
        lat_load   <= (mren_c != 2'b00);
        lat_size   <= size_c;
        lat_lane   <= addr[1:0];
        lat_rd     <= rd;
        if (state_d == REQ) begin
          mem_req_addr  <= {addr[31:2], 2'b00};
          mem_req_wen   <= (mwen_c != 2'b00);
          mem_req_wmask <= wmask_c;
          mem_req_wdata <= wdata_c;
        end
      end
    end
  end

endmodule
